sync_fifo_prog: RTL

Parametrised synchronous FIFO: next generation of the team's FIFO block, with arbitrary (non-power-of-2) depth, programmable almost-full/almost-empty thresholds, an occupancy count, a high-water-mark register, and write-through-when-full. It sits between a producer and consumer in one clock domain and replaces the fixed-threshold FIFO in new designs. An optional first-word-fall-through read mode is selectable at compile time.

---
 rtl/sync_fifo_pkg.sv | 27 ++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo_prog.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the sync_fifo family: count/pointer widths
// and the wrap-at-depth pointer increment used for non-power-of-2 depths.
package sync_fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit compare against depth-1 so arbitrary depths wrap correctly.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        logic [31:0] nxt_s;
        if (ptr == 32'(depth - 1)) begin
            nxt_s = 32'd0;
        end else begin
            nxt_s = ptr + 32'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-write, single-read storage array for sync_fifo_prog.
// Synchronous write, asynchronous read; contents are never reset.
module sync_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, programmable almost thresholds, count,
// high-water mark and write-through-when-full. Define SYNC_FIFO_FWFT_EN for FWFT reads.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int CW        = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  clr_hwm,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         hwm
);

    localparam int PW = ptr_width(FIFO_DEPTH);

    logic [PW-1:0]         wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CW-1:0]         count_r, hwm_r, count_next_s, hwm_next_s;
    logic                  wr_ack_r, overflow_r, underflow_r;
    logic                  rd_ok_s, wr_ok_s, empty_s, full_s;
    logic [FIFO_WIDTH-1:0] rdata_s;

    sync_fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok_s),
        .waddr (wr_ptr_r),
        .wdata (data_in),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CW'(FIFO_DEPTH));
    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign rd_ok_s = rd_en && !empty_s;
    assign wr_ok_s = wr_en && (!full_s || rd_ok_s);

    // Next occupancy, pointers and high-water mark.
    always_comb begin
        count_next_s  = count_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        hwm_next_s    = hwm_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
        if (wr_ok_s) begin
            wr_ptr_next_s = PW'(ptr_inc(32'(wr_ptr_r), FIFO_DEPTH));
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (rd_ok_s) begin
            rd_ptr_next_s = PW'(ptr_inc(32'(rd_ptr_r), FIFO_DEPTH));
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (clr_hwm || (count_next_s > hwm_r)) begin
            hwm_next_s = count_next_s;
        end else begin
            hwm_next_s = hwm_r;
        end
    end

    // Pointer, occupancy and strobe state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            hwm_r       <= {CW{1'b0}};
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            hwm_r       <= hwm_next_s;
            wr_ack_r    <= wr_ok_s;
            overflow_r  <= wr_en && !wr_ok_s;
            underflow_r <= rd_en && !rd_ok_s;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty_s ? {FIFO_WIDTH{1'b0}} : rdata_s;
`else
    logic [FIFO_WIDTH-1:0] data_out_r;

    // Registered read data, held between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= {FIFO_WIDTH{1'b0}};
        end else if (rd_ok_s) begin
            data_out_r <= rdata_s;
        end
    end

    assign data_out = data_out_r;
`endif

    assign wr_ack      = wr_ack_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;
    assign count       = count_r;
    assign hwm         = hwm_r;
    assign empty       = empty_s;
    assign full        = full_s;
    assign almostfull  = (count_r >= CW'(AF_THRESH));
    assign almostempty = !empty_s && (count_r <= CW'(AE_THRESH));

endmodule
